// File: rtl/shift_rot_pipe.sv
// Pipelined log shifter/rotator (ROL/SLL/ROR/SRL), one registered stage per amount bit; latency SHW cycles.
// All stages advance together when the output slot is free or consumed; a stalled output freezes the pipe.
module shift_rot_pipe #(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW:0]     occupancy
);

    logic [SHW-1:0]            vld_q, vld_d;
    logic [SHW-1:0][WIDTH-1:0] dat_q, dat_d;
    // The last stage only delivers its result, so op/amt stop one stage short.
    logic [SHW-2:0][SHW-1:0]   amt_q, amt_d;
    logic [SHW-2:0][1:0]       op_q, op_d;
    logic [SHW:0]              occ_d;
    logic                      advance;
    logic                      accept;

    // sh is either 0 or a single power of two; 0 returns d unchanged for every op.
    function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] d,
                                                     input logic [1:0]       op,
                                                     input logic [SHW-1:0]   sh);
        logic [WIDTH-1:0] r;
        unique case (op)
            2'b00:   r = (d << sh) | (d >> (WIDTH - int'(sh)));
            2'b01:   r = d << sh;
            2'b10:   r = (d >> sh) | (d << (WIDTH - int'(sh)));
            default: r = d >> sh;
        endcase
        return r;
    endfunction

    function automatic logic [SHW:0] popcnt(input logic [SHW-1:0] v);
        logic [SHW:0] c;
        c = '0;
        for (int i = 0; i < SHW; i++) begin
            c = c + {{SHW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    assign advance   = !vld_q[SHW-1] || out_ready;
    assign in_ready  = advance && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = vld_q[SHW-1];
    assign out_data  = dat_q[SHW-1];

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        amt_d = amt_q;
        op_d  = op_q;
        if (advance) begin
            vld_d[0] = accept;
            dat_d[0] = stage_shift(in_data, in_op, in_amt & SHW'(1));
            amt_d[0] = in_amt;
            op_d[0]  = in_op;
            for (int k = 1; k < SHW; k++) begin
                vld_d[k] = vld_q[k-1];
                dat_d[k] = stage_shift(dat_q[k-1], op_q[k-1], amt_q[k-1] & SHW'(1 << k));
            end
            for (int k = 1; k < SHW - 1; k++) begin
                amt_d[k] = amt_q[k-1];
                op_d[k]  = op_q[k-1];
            end
        end
        if (flush) begin
            vld_d = '0;
        end
        occ_d = popcnt(vld_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= '0;
            dat_q     <= '0;
            amt_q     <= '0;
            op_q      <= '0;
            occupancy <= '0;
        end else begin
            vld_q     <= vld_d;
            dat_q     <= dat_d;
            amt_q     <= amt_d;
            op_q      <= op_d;
            occupancy <= occ_d;
        end
    end

endmodule
